div: RTL and testbench
======================

Name: div

Overview:
- Multi-cycle 32-bit integer divider for MIPS DIV/DIVU.
- Sits beside the execute stage.
  - ex supplies latched operands plus a start request, and holds stallreq_o high until ready_o.
  - ex then forwards {remainder, quotient} to HI/LO via hi_o/lo_o/whilo_o.
- Runs one restoring-division iteration per cycle.
- Supports annulment when the instruction is squashed.

Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH bits.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  WIDTH  dividend (rs)
- opdata2_i  in  WIDTH  divisor (rt)
- start_i  in  1  divide request, level held by ex until ready_o seen
- annul_i  in  1  abort the current operation
- result_o  out  2*WIDTH  {remainder[63:32], quotient[31:0]}
- ready_o  out  1  result valid

Behaviour:
- Reset, synchronous and active-high:
  - state = DivFree, result_o = 0, ready_o = 0, cnt = 0.
  - Reset overrides every state, including mid-division.
- FSM states are DivFree, DivByZero, DivOn, DivEnd. All outputs are registered.
- DivFree:
  - On an edge with start_i=1 and annul_i=0:
    - If opdata2_i==0, go to DivByZero.
    - Otherwise, go to DivOn with:
      - cnt=0
      - abs operands latched: if signed_div_i and op[31], take two's complement; else use as is
      - signs latched
      - dividend reg (2*WIDTH+1 bits) = {WIDTH zeros, abs_op1, 1'b0}
  - Otherwise stay, with ready_o=0 and result_o=0.
- DivByZero: next edge goes to DivEnd with result_o=0 and ready_o=1.
- DivOn:
  - annul_i=1 at an edge: go to DivFree, ready_o=0, result_o=0, no result is produced.
  - Else, while cnt<WIDTH:
    - diff = dividend[2W:W] - {1'b0, abs_op2}
    - If diff is negative, dividend <<= 1.
    - Else dividend = {diff[W-1:0], dividend[W-1:0], 1'b1}.
    - cnt++.
  - When cnt==WIDTH:
    - quotient = dividend[W-1:0], negated if signed and sign1^sign2.
    - remainder = dividend[2W:W+1], negated if signed and sign1.
    - result_o = {remainder, quotient}, ready_o=1, go to DivEnd.
- DivEnd:
  - Hold result_o and ready_o=1 while start_i=1.
  - At an edge with start_i=0, go to DivFree, ready_o=0, result_o=0.
- Latency, where edge E0 is the edge that samples start_i in DivFree:
  - Normal division: iterations occur on E1..E32; ready_o=1 after E33.
  - Divide by zero: ready_o=1 after E1.
- Operand changes after E0 are ignored.
- start_i in DivOn/DivEnd is not a new request. A new division requires passing through DivFree.
- 0x80000000 / 0xFFFFFFFF signed:
  - quotient = 0x80000000 (wraps), remainder = 0.
  - No exception is raised.
- annul_i in DivEnd or DivByZero has no effect; the normal exit rule applies.
- Signed results follow truncation toward zero; the remainder takes the dividend's sign.

Decomposition:
- Shared defines.v constants:
  - DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11
  - DivResultReady=1'b1, DivResultNotReady=1'b0
  - DivStart=1'b1, DivStop=1'b0
  - EXE_DIV_OP, EXE_DIVU_OP aluop codes
  - DoubleRegBus width macro
- No sub-module is needed.
  - The negate/abs helpers are inline expressions.
  - The FSM and datapath live in one always block plus a combinational diff.

Test Plan:
- Unsigned, signed_div_i=0: op1=100, op2=7, start held.
  - ready_o rises after E33.
  - result_o = {32'd2, 32'd14}.
  - Dropping start_i returns ready_o to 0 next cycle.
- Signed, signed_div_i=1: op1=-7 (0xFFFFFFF9), op2=2.
  - quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF.
  - Also check op1=7, op2=-2: quotient = 0xFFFFFFFD, remainder = 1.
- Divide by zero: op1=5, op2=0.
  - ready_o=1 after E1.
  - result_o = 0.
- Annul: start a divide of 1000/3, assert annul_i at E10.
  - DivFree at E11; ready_o never asserts.
  - A following 9/3 completes with {0, 3} on schedule.
- Corner and operand-hold cases:
  - Signed 0x80000000 / 0xFFFFFFFF gives {0, 0x80000000}.
  - Unsigned 0xFFFFFFFF / 1 gives {0, 0xFFFFFFFF}.
  - Operand inputs toggled during DivOn do not change the result.
- Reset mid-op: assert rst at E15 of a division.
  - Next cycle: ready_o=0 and result_o=0.
  - A new start after reset behaves exactly as the first scenario.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle MIPS DIV/DIVU unit: FSM encoding,
// handshake levels and the ALU op codes ex uses to route DIV/DIVU here.
package div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  localparam int DoubleRegBusW = 64;

endpackage

// File: rtl/div.sv
// Restoring divider, one quotient bit per cycle. Operands are reduced to
// magnitudes at accept time and signs are re-applied when the last bit lands.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   dividend_q, dividend_d;
  logic [WIDTH-1:0]   op2_q, op2_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   abs_op1, abs_op2, quot, rem;

  // Partial remainder with the next dividend bit appended, minus divisor.
  assign diff    = dividend_q[2*WIDTH:WIDTH] - {1'b0, op2_q};
  assign abs_op1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs_op2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
  assign quot    = (sign1_q ^ sign2_q) ? -dividend_q[WIDTH-1:0] : dividend_q[WIDTH-1:0];
  assign rem     = sign1_q ? -dividend_q[2*WIDTH:WIDTH+1] : dividend_q[2*WIDTH:WIDTH+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= '0;
      dividend_q <= '0;
      op2_q      <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      op2_q      <= op2_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    op2_d      = op2_q;
    sign1_d    = sign1_q;
    sign2_d    = sign2_q;
    result_d   = result_q;
    ready_d    = ready_q;
    unique case (state_q)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            state_d    = DivOn;
            cnt_d      = '0;
            op2_d      = abs_op2;
            sign1_d    = signed_div_i & opdata1_i[WIDTH-1];
            sign2_d    = signed_div_i & opdata2_i[WIDTH-1];
            dividend_d = {{WIDTH{1'b0}}, abs_op1, 1'b0};
          end
        end
      end
      DivByZero: begin
        state_d  = DivEnd;
        result_d = '0;
        ready_d  = DivResultReady;
      end
      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt_q != CNT_W'(WIDTH)) begin
          if (diff[WIDTH]) dividend_d = {dividend_q[2*WIDTH-1:0], 1'b0};
          else             dividend_d = {diff[WIDTH-1:0], dividend_q[WIDTH-1:0], 1'b1};
          cnt_d = cnt_q + 1'b1;
        end else begin
          state_d  = DivEnd;
          result_d = {rem, quot};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        // Result is held until ex drops the request.
        if (start_i == DivStop) begin
          state_d  = DivFree;
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for the divider: latency, signed/unsigned results,
// divide-by-zero, annulment, operand hold and mid-operation reset.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_tests = 0;
  int n_fail  = 0;

  div #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs and samples sit 1 time unit after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input logic toggle);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    tick(1);                               // E0
    if (toggle) begin
      opdata1_i    = 32'hDEAD_BEEF;
      opdata2_i    = 32'h0000_0000;
      signed_div_i = ~sgn;
    end
    tick(32);                              // E32
    chk({tag, "_notready_e32"}, {63'd0, ready_o}, 64'd0);
    tick(1);                               // E33
    chk({tag, "_ready_e33"}, {63'd0, ready_o}, 64'd1);
    chk({tag, "_result"}, result_o, exp);
    tick(2);
    chk({tag, "_hold"}, result_o, exp);
    start_i = 1'b0;
    tick(1);
    chk({tag, "_drop_ready"}, {63'd0, ready_o}, 64'd0);
    chk({tag, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    tick(2);
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    rst = 1'b0;
    tick(1);

    run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
    run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0);
    run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
    run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0);
    run_div("u_max_16", 1'b0, 32'hFFFF_FFFF, 32'h10, {32'hF, 32'h0FFF_FFFF}, 1'b0);
    run_div("hold_ops", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 1'b1);

    // Divide by zero
    signed_div_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0; start_i = 1'b1;
    tick(1);                               // E0
    chk("dz_e0_ready", {63'd0, ready_o}, 64'd0);
    tick(1);                               // E1
    chk("dz_e1_ready", {63'd0, ready_o}, 64'd1);
    chk("dz_e1_result", result_o, 64'd0);
    annul_i = 1'b1;                        // ignored in DivEnd
    tick(1);
    chk("dz_annul_hold", {63'd0, ready_o}, 64'd1);
    annul_i = 1'b0; start_i = 1'b0;
    tick(1);
    chk("dz_drop_ready", {63'd0, ready_o}, 64'd0);

    // Annul mid-division, then confirm the unit is usable again
    opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    tick(1);                               // E0
    tick(9);                               // E1..E9
    annul_i = 1'b1;
    tick(1);                               // E10 samples annul
    annul_i = 1'b0; start_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready_o) seen++;
      tick(1);
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    chk("annul_result", result_o, 64'd0);
    run_div("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

    // Reset in the middle of a division
    opdata1_i = 32'd12345; opdata2_i = 32'd11; start_i = 1'b1;
    tick(1);                               // E0
    tick(14);                              // E1..E14
    rst = 1'b1; start_i = 1'b0;
    tick(1);                               // E15
    rst = 1'b0;
    chk("rst_mid_ready", {63'd0, ready_o}, 64'd0);
    chk("rst_mid_result", result_o, 64'd0);
    tick(1);
    run_div("after_rst", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
